// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// MEM-stage load/store unit. Takes the EX/MEM register outputs (ALU result as
// the effective address, load/store control, store data) and runs one access
// on a multi-cycle req/ack data-memory port. The pipeline is stalled while the
// access is outstanding. Handles byte/half/word lane steering, load sign/zero
// extension, alignment checking and an ack-timeout bus error.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   mem_read_M      load in MEM
//   mem_write_M     store in MEM (wins over mem_read_M)
//   size_M          00 byte, 01 half, 10 word, 11 reserved (always misaligned)
//   unsigned_M      1: zero-extend loads, 0: sign-extend
//   overflow_M      ALU overflow, suppresses the access
//   addr_M          effective address
//   store_data_M    store data (rt)
//   dmem_req/we/addr/be/wdata   registered memory request
//   dmem_rdata, dmem_ack        memory response (rdata valid with ack)
//   load_data, load_valid       registered load result and one-cycle pulse
//   stall_M         combinational stall for PC, IF/ID, ID/EX, EX/MEM
//   addr_err        one-cycle pulse, misaligned access
//   bus_err         one-cycle pulse, no ack within MAX_WAIT cycles
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read_M,
    input  logic          mem_write_M,
    input  logic [1:0]    size_M,
    input  logic          unsigned_M,
    input  logic          overflow_M,
    input  logic [DW-1:0] addr_M,
    input  logic [DW-1:0] store_data_M,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic [DW-1:0] load_data,
    output logic          load_valid,
    output logic          stall_M,
    output logic          addr_err,
    output logic          bus_err
);

    // Wide enough to hold MAX_WAIT-1 with headroom.
    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] load_data_q, load_data_d;
    logic          load_valid_q, load_valid_d;
    logic          addr_err_q, addr_err_d;
    logic          bus_err_q, bus_err_d;

    // Access attributes captured at request time so the load result does not
    // depend on the EX/MEM register staying frozen.
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    off_q, off_d;

    logic          op;
    logic          aligned;
    logic [3:0]    be_new;
    logic [DW-1:0] wdata_new;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [DW-1:0] rd_ext;

    assign op = (mem_read_M | mem_write_M) & ~overflow_M;

    // Alignment, byte enables and store-lane replication for the new access.
    always_comb begin
        aligned   = 1'b0;
        be_new    = 4'b0000;
        wdata_new = store_data_M;
        unique case (size_M)
            2'b00: begin
                aligned   = 1'b1;
                be_new    = 4'b0001 << addr_M[1:0];
                wdata_new = {4{store_data_M[7:0]}};
            end
            2'b01: begin
                aligned   = ~addr_M[0];
                be_new    = addr_M[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_data_M[15:0]}};
            end
            2'b10: begin
                aligned   = (addr_M[1:0] == 2'b00);
                be_new    = 4'b1111;
                wdata_new = store_data_M;
            end
            2'b11: begin
                aligned   = 1'b0;
                be_new    = 4'b0000;
                wdata_new = store_data_M;
            end
        endcase
    end

    // Lane extraction and extension of the returned read data.
    assign rd_byte = dmem_rdata[{off_q, 3'b000} +: 8];
    assign rd_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        rd_ext = dmem_rdata;
        unique case (size_q)
            2'b00:   rd_ext = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = dmem_rdata;
        endcase
    end

    // Next-state and combinational outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        addr_err_d   = 1'b0;
        bus_err_d    = 1'b0;
        stall_M      = 1'b0;

        case (state_q)
            StIdle: begin
                if (op) begin
                    if (!aligned) begin
                        // Faulting access never reaches the memory port.
                        addr_err_d = 1'b1;
                    end else begin
                        stall_M = 1'b1;
                        req_d   = 1'b1;
                        we_d    = mem_write_M;
                        addr_d  = {addr_M[DW-1:2], 2'b00};
                        be_d    = be_new;
                        wdata_d = wdata_new;
                        size_d  = size_M;
                        uns_d   = unsigned_M;
                        off_d   = addr_M[1:0];
                        cnt_d   = '0;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                stall_M = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                // Ack is checked first so an ack on the timeout cycle wins.
                if (dmem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        load_data_d  = rd_ext;
                        load_valid_d = 1'b1;
                    end
                    state_d = StDone;
                end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                // Pipeline advances on this edge; the instruction still sitting
                // in EX/MEM has completed and must not be reissued.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= 4'b0000;
            wdata_q      <= '0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            addr_err_q   <= addr_err_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign addr_err   = addr_err_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//
// Drives single MEM-stage accesses the way a pipeline would (the instruction
// is held while stall_M is high and replaced by a bubble once it drops),
// answers the memory port with a programmable ack delay, and compares what it
// observes against a directed table and against a reference model for random
// accesses. Also covers reset during an outstanding access.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int unsigned MAX_WAIT = 16;
    localparam int          WINDOW   = 22;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_M, mem_write_M, unsigned_M, overflow_M;
    logic [1:0]  size_M;
    logic [31:0] addr_M, store_data_M;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data;
    logic [3:0]  dmem_be;
    logic        load_valid, stall_M, addr_err, bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DW       (32),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_M   (mem_read_M),
        .mem_write_M  (mem_write_M),
        .size_M       (size_M),
        .unsigned_M   (unsigned_M),
        .overflow_M   (overflow_M),
        .addr_M       (addr_M),
        .store_data_M (store_data_M),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .stall_M      (stall_M),
        .addr_err     (addr_err),
        .bus_err      (bus_err)
    );

    // ack_at: BUSY cycle (1-based) on which ack is given; 0 or > MAX_WAIT = never.
    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic        ovf;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          ack_at;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        int          e_stall;
        int          e_req;
        int          e_lv;
        logic [31:0] e_ld;
        int          e_aerr;
        int          e_berr;
    } vec_t;

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got 0x%08h, expected 0x%08h", name, idx, got, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rd, input logic wr, input logic [1:0] size, input logic uns,
        input logic ovf, input logic [31:0] addr, input logic [31:0] sdata,
        input logic [31:0] rdata, input int ack_at, input logic e_we,
        input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata,
        input int e_stall, input int e_req, input int e_lv, input logic [31:0] e_ld,
        input int e_aerr, input int e_berr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.ovf = ovf;
        v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.ack_at = ack_at;
        v.e_we = e_we; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
        v.e_stall = e_stall; v.e_req = e_req; v.e_lv = e_lv; v.e_ld = e_ld;
        v.e_aerr = e_aerr; v.e_berr = e_berr;
        return v;
    endfunction

    // Reference model: expected observations from the access rules alone.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        bit          op, al, acked;
        int          off;
        logic [31:0] x;
        r     = v;
        op    = (v.rd || v.wr) && !v.ovf;
        off   = int'(v.addr % 32'd4);
        acked = (v.ack_at >= 1) && (v.ack_at <= int'(MAX_WAIT));
        case (v.size)
            2'd0:    al = 1'b1;
            2'd1:    al = (off % 2 == 0);
            2'd2:    al = (off == 0);
            default: al = 1'b0;
        endcase
        r.e_we   = v.wr;
        r.e_addr = v.addr - 32'(off);
        case (v.size)
            2'd0: begin
                r.e_be    = 4'(1 << off);
                r.e_wdata = (v.sdata & 32'hFF) * 32'h0101_0101;
                x = (v.rdata >> (8 * off)) & 32'hFF;
                if (!v.uns && x >= 32'd128) x = x - 32'd256;
            end
            2'd1: begin
                r.e_be    = (off >= 2) ? 4'hC : 4'h3;
                r.e_wdata = (v.sdata & 32'hFFFF) * 32'h0001_0001;
                x = (v.rdata >> (16 * (off / 2))) & 32'hFFFF;
                if (!v.uns && x >= 32'd32768) x = x - 32'd65536;
            end
            default: begin
                r.e_be    = 4'hF;
                r.e_wdata = v.sdata;
                x = v.rdata;
            end
        endcase
        r.e_stall = (op && al) ? (acked ? v.ack_at + 1 : int'(MAX_WAIT) + 1) : 0;
        r.e_req   = (op && al) ? (acked ? v.ack_at : int'(MAX_WAIT)) : 0;
        r.e_lv    = (op && al && acked && !v.wr) ? 1 : 0;
        r.e_ld    = x;
        r.e_aerr  = (op && !al) ? 1 : 0;
        r.e_berr  = (op && al && !acked) ? 1 : 0;
        return r;
    endfunction

    task automatic set_nop();
        mem_read_M   = 1'b0;
        mem_write_M  = 1'b0;
        size_M       = 2'b00;
        unsigned_M   = 1'b0;
        overflow_M   = 1'b0;
        addr_M       = 32'h0;
        store_data_M = 32'h0;
    endtask

    // Called just after a rising edge with the DUT idle.
    task automatic run_vec(input vec_t v, input int idx);
        int          n_stall = 0, n_req = 0, n_lv = 0, n_aerr = 0, n_berr = 0;
        bit          active = 1'b1, prev_s = 1'b0, s, lv_done = 1'b0, unstable = 1'b0;
        logic        c_we = 1'b0;
        logic [31:0] c_addr = 32'h0, c_wdata = 32'h0, ld = 32'h0;
        logic [3:0]  c_be = 4'h0;

        mem_read_M   = v.rd;
        mem_write_M  = v.wr;
        size_M       = v.size;
        unsigned_M   = v.uns;
        overflow_M   = v.ovf;
        addr_M       = v.addr;
        store_data_M = v.sdata;

        for (int c = 0; c < WINDOW; c++) begin
            @(negedge clk);
            s = stall_M;
            if (dmem_req) begin
                n_req++;
                if (n_req == 1) begin
                    c_we = dmem_we; c_addr = dmem_addr; c_be = dmem_be; c_wdata = dmem_wdata;
                end else if (dmem_we !== c_we || dmem_addr !== c_addr ||
                             dmem_be !== c_be || dmem_wdata !== c_wdata) begin
                    unstable = 1'b1;
                end
            end
            dmem_ack   = dmem_req && (n_req == v.ack_at);
            dmem_rdata = dmem_ack ? v.rdata : $urandom();
            if (s) n_stall++;
            if (load_valid) begin
                n_lv++;
                ld = load_data;
                if (prev_s && !s) lv_done = 1'b1;
            end
            if (addr_err) n_aerr++;
            if (bus_err) n_berr++;
            prev_s = s;
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            if (active && !s) begin
                set_nop();
                active = 1'b0;
            end
        end

        check("stall_cycles", idx, 32'(n_stall), 32'(v.e_stall));
        check("req_cycles", idx, 32'(n_req), 32'(v.e_req));
        check("addr_err_pulses", idx, 32'(n_aerr), 32'(v.e_aerr));
        check("bus_err_pulses", idx, 32'(n_berr), 32'(v.e_berr));
        check("load_valid_pulses", idx, 32'(n_lv), 32'(v.e_lv));
        if (v.e_req > 0) begin
            check("dmem_we", idx, {31'b0, c_we}, {31'b0, v.e_we});
            check("dmem_addr", idx, c_addr, v.e_addr);
            check("dmem_be", idx, {28'b0, c_be}, {28'b0, v.e_be});
            check("dmem_wdata", idx, c_wdata, v.e_wdata);
            check("req_stable", idx, {31'b0, unstable}, 32'h0);
        end
        if (v.e_lv > 0) begin
            check("load_data", idx, ld, v.e_ld);
            check("load_valid_in_done", idx, {31'b0, lv_done}, 32'h1);
        end
    endtask

    vec_t tbl[14];
    vec_t rv;

    initial begin
        // rd wr sz uns ovf addr sdata rdata ack | we addr be wdata stall req lv ld aerr berr
        tbl[0]  = mk(1, 0, 2, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3,
                     0, 32'h100, 4'hF, 32'h0, 4, 3, 1, 32'hDEADBEEF, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 32'h103, 32'h0, 32'h80112233, 1,
                     0, 32'h100, 4'h8, 32'h0, 2, 1, 1, 32'hFFFFFF80, 0, 0);
        tbl[2]  = mk(1, 0, 0, 1, 0, 32'h103, 32'h0, 32'h80112233, 1,
                     0, 32'h100, 4'h8, 32'h0, 2, 1, 1, 32'h00000080, 0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 0, 32'h206, 32'h0000ABCD, 32'h0, 1,
                     1, 32'h204, 4'hC, 32'hABCDABCD, 2, 1, 0, 32'h0, 0, 0);
        tbl[4]  = mk(1, 0, 2, 0, 0, 32'h102, 32'h0, 32'h0, 1,
                     0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0, 1, 0);
        tbl[5]  = mk(0, 1, 2, 0, 1, 32'h300, 32'h1, 32'h0, 1,
                     0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
        tbl[6]  = mk(1, 0, 2, 0, 0, 32'h300, 32'h0, 32'h5555, 0,
                     0, 32'h300, 4'hF, 32'h0, 17, 16, 0, 32'h0, 0, 1);
        tbl[7]  = mk(1, 0, 2, 0, 0, 32'h304, 32'h0, 32'hCAFEF00D, 16,
                     0, 32'h304, 4'hF, 32'h0, 17, 16, 1, 32'hCAFEF00D, 0, 0);
        tbl[8]  = mk(1, 0, 3, 0, 0, 32'h0, 32'h0, 32'h0, 1,
                     0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0, 1, 0);
        tbl[9]  = mk(1, 0, 1, 0, 0, 32'h202, 32'h0, 32'h80010000, 2,
                     0, 32'h200, 4'hC, 32'h0, 3, 2, 1, 32'hFFFF8001, 0, 0);
        tbl[10] = mk(1, 1, 2, 0, 0, 32'h10, 32'h12345678, 32'h0, 1,
                     1, 32'h10, 4'hF, 32'h12345678, 2, 1, 0, 32'h0, 0, 0);
        tbl[11] = mk(0, 1, 0, 0, 0, 32'h105, 32'h000000A5, 32'h0, 2,
                     1, 32'h104, 4'h2, 32'hA5A5A5A5, 3, 2, 0, 32'h0, 0, 0);
        tbl[12] = mk(1, 0, 1, 0, 0, 32'h201, 32'h0, 32'h0, 1,
                     0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0, 1, 0);
        tbl[13] = mk(1, 0, 1, 1, 0, 32'h20, 32'h0, 32'h1234F00D, 1,
                     0, 32'h20, 4'h3, 32'h0, 2, 1, 1, 32'h0000F00D, 0, 0);

        set_nop();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        rst        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_dmem_req", -1, {31'b0, dmem_req}, 32'h0);
        check("rst_dmem_we", -1, {31'b0, dmem_we}, 32'h0);
        check("rst_dmem_addr", -1, dmem_addr, 32'h0);
        check("rst_dmem_be", -1, {28'b0, dmem_be}, 32'h0);
        check("rst_dmem_wdata", -1, dmem_wdata, 32'h0);
        check("rst_load_data", -1, load_data, 32'h0);
        check("rst_flags", -1, {28'b0, load_valid, addr_err, bus_err, stall_M}, 32'h0);
        @(posedge clk);
        #1;

        foreach (tbl[i]) run_vec(tbl[i], i);

        // Reset on the 2nd BUSY cycle, then a stray ack one cycle later.
        mem_read_M = 1'b1;
        size_M     = 2'b10;
        addr_M     = 32'h400;
        @(negedge clk);
        check("rstbusy_idle_stall", 100, {31'b0, stall_M}, 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstbusy_req_busy1", 100, {31'b0, dmem_req}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_nop();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstbusy_req_after", 100, {31'b0, dmem_req}, 32'h0);
        check("rstbusy_stall_after", 100, {31'b0, stall_M}, 32'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stray_ack_flags", 100 + c,
                  {28'b0, load_valid, bus_err, dmem_req, stall_M}, 32'h0);
        end
        @(posedge clk);
        #1;

        // Randomized accesses against the reference model.
        for (int i = 0; i < 60; i++) begin
            rv.rd     = 1'($urandom_range(0, 1));
            rv.wr     = 1'($urandom_range(0, 1));
            rv.size   = 2'($urandom_range(0, 3));
            rv.uns    = 1'($urandom_range(0, 1));
            rv.ovf    = ($urandom_range(0, 7) == 0);
            rv.addr   = $urandom();
            rv.sdata  = $urandom();
            rv.rdata  = $urandom();
            rv.ack_at = int'($urandom_range(0, 18));
            run_vec(model(rv), 200 + i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs (ALU result as address, control, store data) and drives the data-memory port.
- Multi-cycle req/ack memory interface; stalls the pipeline while an access is outstanding.
- Performs byte/half/word lane steering, load sign/zero extension, alignment checking and an ack-timeout bus-error check.
- Result feeds the MEM/WB register.

Parameters:
- DW, 32, data/address width (fixed at 32; byte-lane logic assumes 4 lanes).
- MAX_WAIT, 16, maximum cycles dmem_req stays high without dmem_ack before a bus error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read_M  in  1  load in MEM.
- mem_write_M  in  1  store in MEM; if both are set, the write takes priority.
- size_M  in  2  00 byte, 01 half, 10 word, 11 reserved (always an alignment error).
- unsigned_M  in  1  zero-extend loads when 1, sign-extend when 0.
- overflow_M  in  1  ALU overflow; suppresses the access entirely.
- addr_M  in  DW  effective address (ALU result).
- store_data_M  in  DW  rt value for stores.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  write enable, registered.
- dmem_addr  out  DW  {addr_M[31:2],2'b00}, registered.
- dmem_be  out  4  byte enables, registered.
- dmem_wdata  out  DW  lane-replicated store data, registered.
- dmem_rdata  in  DW  read data, valid with dmem_ack.
- dmem_ack  in  1  single-cycle completion.
- load_data  out  DW  extended load result, registered.
- load_valid  out  1  one-cycle pulse with load_data.
- stall_M  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- addr_err  out  1  one-cycle registered pulse.
- bus_err  out  1  one-cycle registered pulse.

Behaviour:
- Reset: state IDLE, wait counter 0. All registered outputs (dmem_req/we/addr/be/wdata, load_data, load_valid, addr_err, bus_err) are 0.
- op = (mem_read_M | mem_write_M) & ~overflow_M.
- aligned conditions: byte always; half requires addr[0]==0; word requires addr[1:0]==0; size 11 is never aligned.
- IDLE:
  - op & ~aligned: addr_err=1 next cycle; no request; stall_M=0; stay IDLE.
  - op & aligned: stall_M=1 this cycle. Next edge: dmem_req=1, we/addr/be/wdata latched, counter cleared, enter BUSY.
  - no op, or overflow_M=1: nothing happens; stall_M=0.
- Byte enables (little-endian): byte 0001<<addr[1:0]; half addr[1]?1100:0011; word 1111.
- Store data: byte is {4{d[7:0]}}; half is {2{d[15:0]}}; word is d.
- BUSY:
  - stall_M=1; request outputs held stable; counter increments each cycle.
  - dmem_ack=1: next edge dmem_req=0. For loads, load_data = lane-extracted dmem_rdata extended per size/unsigned_M, and load_valid=1. Enter DONE.
  - No ack, counter==MAX_WAIT-1: next edge dmem_req=0, bus_err=1, load_valid=0, enter DONE.
  - Ack arriving on the same cycle as the timeout: the ack wins, no bus_err.
- DONE: stall_M=0 so the pipeline advances this edge. Unconditionally return to IDLE; the held instruction is never reissued. load_valid, bus_err and addr_err self-clear after one cycle.
- Latency: an access with ack on the k-th BUSY cycle gives k+1 stall cycles. load_valid appears in the DONE cycle.
- dmem_ack outside BUSY: ignored.
- rst mid-BUSY: next edge dmem_req=0, IDLE, no load_valid, no bus_err.
- dmem_rdata is sampled only on the ack cycle.

Test Plan:
- Word load at addr 0x100, ack on 3rd BUSY cycle, rdata 0xDEADBEEF -> dmem_addr 0x100, be 1111, stall_M high 4 cycles, load_valid pulse, load_data 0xDEADBEEF.
- Signed byte load at addr 0x103, rdata 0x80112233 -> be 1000, load_data 0xFFFFFF80. Same access with unsigned_M=1 -> 0x00000080.
- Half store at addr 0x206, data 0x0000ABCD, immediate ack -> dmem_we=1, be 1100, wdata 0xABCDABCD, dmem_addr 0x204, 2 stall cycles.
- Word load at addr 0x102 -> addr_err pulse, no dmem_req, stall_M never high. Separately, overflow_M=1 with a store -> no request and no error.
- No ack with MAX_WAIT=16 -> dmem_req high 16 cycles, then bus_err pulse, stall released, load_valid stays 0.
- rst asserted on the 2nd BUSY cycle -> dmem_req 0 and stall_M 0 next cycle. An ack arriving one cycle later is ignored.
